ui_mode_ctrl: RTL
=================

UI_MODE_CTRL -- requirements
Module: ui_mode_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV_1MS, default 24000, meaning clock cycles per 1 ms tick (24 MHz clock).
REQ-002 SHALL have parameter TIMEOUT_MS, default 10000, meaning idle time before filter edit is abandoned.
REQ-003 SHALL have parameter BLINK_MS, default 250, meaning half-period of the edit blink output.
REQ-004 SHALL have i_clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have i_res_n, input, 1, meaning the reset: asynchronous assert, active-low.
REQ-006 SHALL have i_a_short, i_a_long, i_b_short, i_b_long, inputs, 1 each, meaning single-cycle press-event pulses for buttons A and B.
REQ-007 SHALL have i_buf_count, input, 10, meaning the number of valid captured entries (0..1023).
REQ-008 SHALL have o_mode, output, 2, meaning the current state: 0 RUN, 1 HOLD, 2 EDIT, 3 CLEAR.
REQ-009 SHALL have o_capture_en, output, 1, meaning the capture enable for the monitor datapath.
REQ-010 SHALL have o_clear, output, 1, meaning a one-cycle buffer-clear pulse.
REQ-011 SHALL have o_view_idx, output, 10, meaning the displayed entry index.
REQ-012 SHALL have o_filter_en, output, 1, meaning the address filter enable.
REQ-013 SHALL have o_filter_addr, output, 7, meaning the committed 7-bit I2C filter address.
REQ-014 SHALL have o_blink, output, 1, meaning the edit-field blink signal.

Function
REQ-015 SHALL resolve simultaneous events in one cycle by priority a_long > a_short > b_long > b_short; lower-priority events in that cycle are dropped.
REQ-016 In RUN: o_capture_en=1 and o_view_idx=i_buf_count-1, or 0 when the count is 0.
REQ-017 In RUN: a_short goes to HOLD, freezing o_view_idx at its current value; a_long goes to CLEAR; b_short toggles o_filter_en; b_long goes to EDIT with edit_addr loaded from o_filter_addr.
REQ-018 In HOLD: o_capture_en=0; a_short goes to RUN; a_long goes to CLEAR.
REQ-019 In HOLD: b_short increments o_view_idx and wraps to 0 when the next value is >= i_buf_count; b_long sets o_view_idx to 0.
REQ-020 In HOLD with i_buf_count=0: o_view_idx SHALL stay 0.
REQ-021 In EDIT: o_capture_en keeps the value it had on entry; b_short sets edit_addr+1 mod 128; a_short sets edit_addr+16 mod 128.
REQ-022 In EDIT: b_long commits edit_addr to o_filter_addr, sets o_filter_en=1, and goes to RUN; a_long discards the edit and goes to RUN.
REQ-023 In EDIT: the idle counter SHALL count 1 ms ticks, restart on any accepted event, and at TIMEOUT_MS discard the edit and go to RUN.
REQ-024 In EDIT: o_filter_addr SHALL remain the committed value; the edited value is internal until commit.
REQ-025 In EDIT: o_blink SHALL toggle every BLINK_MS ticks starting from 1 on entry; o_blink=0 in every other state.
REQ-026 CLEAR SHALL last exactly one cycle with o_clear=1 and o_view_idx=0, then go to RUN; events arriving during CLEAR are ignored.
REQ-027 All outputs SHALL be registered; a state change is visible on outputs one cycle after the event pulse.
REQ-028 The 1 ms prescaler SHALL free-run from reset, wrapping at CLK_DIV_1MS-1.

Reset
REQ-029 On i_res_n low: state RUN, o_capture_en=1, o_clear=0, o_view_idx=0, o_filter_en=0, o_filter_addr=0, o_blink=0, and all counters 0.
REQ-030 Reset mid-EDIT or mid-CLEAR SHALL abandon the operation with no commit and no clear pulse.

Structure
REQ-031 SHALL place the state encodings (RUN/HOLD/EDIT/CLEAR) and the parameter defaults in the shared package ui_pkg.
REQ-032 SHALL instantiate one sub-module, ms_tick, a parameterised 1 ms enable generator reusable by the other UI blocks.

Verification (bench overrides CLK_DIV_1MS=10, TIMEOUT_MS=20, BLINK_MS=4)
REQ-033 Reset, i_buf_count=5 -> o_mode=0, o_view_idx=4, o_capture_en=1, o_filter_addr=0.
REQ-034 a_short, then 5x b_short at count=5 -> HOLD, capture_en=0, view_idx 4,0,1,2,3,4.
REQ-035 b_long, 3x a_short, 2x b_short, b_long -> o_filter_addr=0x32, o_filter_en=1, RUN.
REQ-036 b_long, b_short, then idle 20 ms -> RUN, o_filter_addr unchanged, o_blink toggled every 40 cycles during EDIT.
REQ-037 a_short and b_short in the same cycle from RUN -> HOLD, filter_en unchanged; a_long -> exactly one o_clear cycle, view_idx=0.
REQ-038 Reset asserted 3 cycles after entering EDIT -> all outputs at REQ-029 values, no commit.

Source files
------------

// File: rtl/ui_pkg.sv
// Shared definitions for the UI mode controller and its helpers.
package ui_pkg;

  // Mode encodings, also driven directly onto o_mode.
  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHold  = 2'd1,
    StEdit  = 2'd2,
    StClear = 2'd3
  } ui_mode_e;

  // Default timing for a 24 MHz system clock.
  localparam int unsigned CLK_DIV_1MS_DEF = 24000;
  localparam int unsigned TIMEOUT_MS_DEF  = 10000;
  localparam int unsigned BLINK_MS_DEF    = 250;

  // The single button event accepted in a cycle.
  typedef enum logic [2:0] {
    EvNone,
    EvALong,
    EvAShort,
    EvBLong,
    EvBShort
  } ui_ev_e;

  // Highest-priority press wins; everything else in that cycle is dropped.
  function automatic ui_ev_e ui_pick_event(input logic a_long, input logic a_short,
                                           input logic b_long, input logic b_short);
    if (a_long) return EvALong;
    if (a_short) return EvAShort;
    if (b_long) return EvBLong;
    if (b_short) return EvBShort;
    return EvNone;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Free-running 1 ms enable generator: one-cycle tick every Div clocks.
module ms_tick #(
  parameter int unsigned Div = 24000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Wrap at Div-1 so the period is exactly Div cycles.
  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/ui_mode_ctrl.sv
// Two-button UI mode controller: run/hold browsing, filter address edit, buffer clear.
module ui_mode_ctrl
  import ui_pkg::*;
#(
  parameter int unsigned CLK_DIV_1MS = CLK_DIV_1MS_DEF,
  parameter int unsigned TIMEOUT_MS  = TIMEOUT_MS_DEF,
  parameter int unsigned BLINK_MS    = BLINK_MS_DEF
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_a_short,
  input  logic       i_a_long,
  input  logic       i_b_short,
  input  logic       i_b_long,
  input  logic [9:0] i_buf_count,
  output logic [1:0] o_mode,
  output logic       o_capture_en,
  output logic       o_clear,
  output logic [9:0] o_view_idx,
  output logic       o_filter_en,
  output logic [6:0] o_filter_addr,
  output logic       o_blink
);

  localparam int unsigned IdleW  = $clog2(TIMEOUT_MS + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_MS + 1);
  localparam logic [IdleW-1:0]  IdleLast  = IdleW'(TIMEOUT_MS - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_MS - 1);

  ui_mode_e          mode_q, mode_d;
  logic              capture_en_q, capture_en_d;
  logic              clear_q, clear_d;
  logic [9:0]        view_idx_q, view_idx_d;
  logic              filter_en_q, filter_en_d;
  logic [6:0]        filter_addr_q, filter_addr_d;
  logic [6:0]        edit_addr_q, edit_addr_d;
  logic              blink_q, blink_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;

  logic       tick;
  ui_ev_e     ev;
  logic [9:0] last_idx;
  logic [10:0] idx_inc;
  logic [9:0] idx_wrap;

  ms_tick #(
    .Div(CLK_DIV_1MS)
  ) u_ms_tick (
    .clk_i (i_clk),
    .rst_ni(i_res_n),
    .tick_o(tick)
  );

  assign ev       = ui_pick_event(i_a_long, i_a_short, i_b_long, i_b_short);
  assign last_idx = (i_buf_count == '0) ? '0 : i_buf_count - 10'd1;
  // Extra bit so the wrap compare also works at the 1023 boundary.
  assign idx_inc  = {1'b0, view_idx_q} + 11'd1;
  assign idx_wrap = (idx_inc >= {1'b0, i_buf_count}) ? '0 : idx_inc[9:0];

  // Next-state and registered-output computation.
  always_comb begin
    mode_d        = mode_q;
    capture_en_d  = capture_en_q;
    clear_d       = 1'b0;
    view_idx_d    = view_idx_q;
    filter_en_d   = filter_en_q;
    filter_addr_d = filter_addr_q;
    edit_addr_d   = edit_addr_q;
    blink_d       = blink_q;
    idle_cnt_d    = idle_cnt_q;
    blink_cnt_d   = blink_cnt_q;

    unique case (mode_q)
      StRun: begin
        unique case (ev)
          EvALong:  mode_d = StClear;
          EvAShort: begin
            mode_d       = StHold;
            capture_en_d = 1'b0;
          end
          EvBLong: begin
            mode_d      = StEdit;
            edit_addr_d = filter_addr_q;
            blink_d     = 1'b1;
          end
          EvBShort: filter_en_d = ~filter_en_q;
          default: ;
        endcase
      end
      StHold: begin
        unique case (ev)
          EvALong:  mode_d = StClear;
          EvAShort: mode_d = StRun;
          EvBLong:  view_idx_d = '0;
          EvBShort: view_idx_d = idx_wrap;
          default: ;
        endcase
      end
      StEdit: begin
        // Any accepted press restarts the idle timeout.
        if (ev != EvNone) begin
          idle_cnt_d = '0;
        end else if (tick) begin
          if (idle_cnt_q == IdleLast) begin
            mode_d = StRun;
          end else begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
          end
        end
        if (tick) begin
          if (blink_cnt_q == BlinkLast) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
          end
        end
        unique case (ev)
          EvALong:  mode_d = StRun;
          EvAShort: edit_addr_d = edit_addr_q + 7'd16;
          EvBLong: begin
            mode_d        = StRun;
            filter_addr_d = edit_addr_q;
            filter_en_d   = 1'b1;
          end
          EvBShort: edit_addr_d = edit_addr_q + 7'd1;
          default: ;
        endcase
      end
      StClear: mode_d = StRun;
      default: mode_d = StRun;
    endcase

    // Output values that depend only on the mode being entered.
    if (mode_d == StRun) begin
      view_idx_d   = last_idx;
      capture_en_d = 1'b1;
    end
    if (mode_d == StClear) begin
      view_idx_d = '0;
      clear_d    = 1'b1;
    end
    if (mode_d != StEdit) begin
      blink_d     = 1'b0;
      idle_cnt_d  = '0;
      blink_cnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      mode_q        <= StRun;
      capture_en_q  <= 1'b1;
      clear_q       <= 1'b0;
      view_idx_q    <= '0;
      filter_en_q   <= 1'b0;
      filter_addr_q <= '0;
      edit_addr_q   <= '0;
      blink_q       <= 1'b0;
      idle_cnt_q    <= '0;
      blink_cnt_q   <= '0;
    end else begin
      mode_q        <= mode_d;
      capture_en_q  <= capture_en_d;
      clear_q       <= clear_d;
      view_idx_q    <= view_idx_d;
      filter_en_q   <= filter_en_d;
      filter_addr_q <= filter_addr_d;
      edit_addr_q   <= edit_addr_d;
      blink_q       <= blink_d;
      idle_cnt_q    <= idle_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
    end
  end

  assign o_mode        = mode_q;
  assign o_capture_en  = capture_en_q;
  assign o_clear       = clear_q;
  assign o_view_idx    = view_idx_q;
  assign o_filter_en   = filter_en_q;
  assign o_filter_addr = filter_addr_q;
  assign o_blink       = blink_q;

endmodule
